// File: rtl/sequence_memory_reader.sv
// sequence_memory_reader: fetches N packed sequence words from the shared RAM s2 port and streams them to the evaluator
// Ports: iClock/iReset (async, active-high); iStart rising edge in IDLE launches a run of
//   iSequencesToProcess words from iBaseAddress; oMemAddress/oMemChipSelect/oMemClken/iMemReadData
//   drive the RAM read port; oSeqValid/iSeqReady handshake carries oSeqInput/oSeqExpected/
//   oSeqValidMask/oSeqIndex/oSeqLast; oBusy/oDone/iDoneAck report run status to the HPS.
// Option: define SEQ_READER_CHECKSUM_EN to add oChecksum, the wrapping sum of all words read this run.
module sequence_memory_reader #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [7:0]        iSequencesToProcess,
    input  logic [ADDR_W-1:0] iBaseAddress,
    output logic [ADDR_W-1:0] oMemAddress,
    output logic              oMemChipSelect,
    output logic              oMemClken,
    input  logic [31:0]       iMemReadData,
    output logic              oSeqValid,
    input  logic              iSeqReady,
    output logic [7:0]        oSeqInput,
    output logic [7:0]        oSeqExpected,
    output logic [7:0]        oSeqValidMask,
    output logic [7:0]        oSeqIndex,
    output logic              oSeqLast,
    output logic              oBusy,
    output logic              oDone,
`ifdef SEQ_READER_CHECKSUM_EN
    output logic [31:0]       oChecksum,
`endif
    input  logic              iDoneAck
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    start_q;
    logic [7:0]              n_q, n_d, issue_q, issue_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [READ_LATENCY-1:0] pv_q, plast_q;
    logic [7:0]              pidx_q [READ_LATENCY];
    logic [23:0]             fdata_q [FIFO_DEPTH];
    logic [7:0]              fidx_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   flast_q;
    logic [PW-1:0]           wp_q, rp_q;
    logic [PW:0]             cnt_q;
    logic [CW-1:0]           inflight;
    logic                    start_edge, issue, pop, wr, last_issue, credit;

    assign start_edge = iStart && !start_q;
    assign wr         = pv_q[READ_LATENCY-1];
    assign pop        = oSeqValid && iSeqReady;
    assign last_issue = issue_q == n_q - 8'd1;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < READ_LATENCY; k++) inflight = inflight + CW'(pv_q[k]);
    end

    // Reads in flight plus buffered entries must fit the FIFO; an entry popped this
    // cycle frees its slot at the same edge, which keeps 1 entry/cycle throughput.
    assign credit = inflight + CW'(cnt_q) < CW'(FIFO_DEPTH) + CW'(pop);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        base_d  = base_q;
        issue_d = issue_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start_edge) begin
                n_d     = iSequencesToProcess;
                base_d  = iBaseAddress;
                issue_d = 8'd0;
                state_d = iSequencesToProcess == 8'd0 ? DONE : FETCH;
            end
            FETCH: if (credit) begin
                issue   = 1'b1;
                issue_d = issue_q + 8'd1;
                state_d = last_issue ? DRAIN : FETCH;
            end
            DRAIN: state_d = pop && oSeqLast ? DONE : DRAIN;
            DONE:  state_d = iDoneAck ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // start_q resets high so a start level held through reset is not seen as an edge.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            start_q <= 1'b1;
            n_q     <= '0;
            base_q  <= '0;
            issue_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= iStart;
            n_q     <= n_d;
            base_q  <= base_d;
            issue_q <= issue_d;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pv_q    <= '0;
            plast_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pv_q    <= (pv_q << 1) | READ_LATENCY'(issue);
            plast_q <= (plast_q << 1) | READ_LATENCY'(issue && last_issue);
            if (wr) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q   <= cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
        end
    end

    // Payload storage needs no reset: every output is gated by oSeqValid.
    always_ff @(posedge iClock) begin
        pidx_q[0] <= issue_q;
        for (int k = 1; k < READ_LATENCY; k++) pidx_q[k] <= pidx_q[k-1];
        if (wr) begin
            fdata_q[wp_q] <= iMemReadData[23:0];
            fidx_q[wp_q]  <= pidx_q[READ_LATENCY-1];
            flast_q[wp_q] <= plast_q[READ_LATENCY-1];
        end
    end

    assign oSeqValid      = cnt_q != '0;
    assign oSeqInput      = oSeqValid ? fdata_q[rp_q][7:0] : 8'd0;
    assign oSeqExpected   = oSeqValid ? fdata_q[rp_q][15:8] : 8'd0;
    assign oSeqValidMask  = oSeqValid ? fdata_q[rp_q][23:16] : 8'd0;
    assign oSeqIndex      = oSeqValid ? fidx_q[rp_q] : 8'd0;
    assign oSeqLast       = oSeqValid && flast_q[rp_q];
    assign oBusy          = state_q == FETCH || state_q == DRAIN;
    assign oDone          = state_q == DONE;
    assign oMemClken      = 1'b1;
    assign oMemChipSelect = issue;
    assign oMemAddress    = base_q + ADDR_W'(issue_q);

`ifdef SEQ_READER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) sum_q <= '0;
        else if (state_q == IDLE && start_edge) sum_q <= '0;
        else if (wr) sum_q <= sum_q + iMemReadData;
    end

    assign oChecksum = sum_q;
`else
    logic unused_hi;
    assign unused_hi = &{1'b0, iMemReadData[31:24]};
`endif
endmodule

// File: tb/tb_sequence_memory_reader.sv
// tb_sequence_memory_reader: randomized directed bench for sequence_memory_reader against a table-driven reference
module tb_sequence_memory_reader;
    localparam int AW = 16;
    localparam int L  = 1;
    localparam int D  = 4;

    typedef logic [32:0] ent_t;

    logic          clk = 1'b0;
    logic          iReset, iStart, iSeqReady, iDoneAck;
    logic [7:0]    iSequencesToProcess;
    logic [AW-1:0] iBaseAddress, oMemAddress;
    logic          oMemChipSelect, oMemClken, oSeqValid, oSeqLast, oBusy, oDone;
    logic [31:0]   iMemReadData;
    logic [7:0]    oSeqInput, oSeqExpected, oSeqValidMask, oSeqIndex;
`ifdef SEQ_READER_CHECKSUM_EN
    logic [31:0]   oChecksum;
`endif

    logic [31:0]   mem [0:65535];
    logic          cs_n;
    logic [AW-1:0] addr_n;
    ent_t          cur, held;
    ent_t          ent_q [$];
    logic [AW-1:0] addr_q [$];
    int            total = 0, bad = 0;
    int            issued = 0, acc = 0, out_viol = 0, stab_viol = 0, cyc = 0;
    int            first_cs, first_v, first_acc, last_acc;
    bit            hold_f = 0, rnd_rdy = 0;

    always #5 clk = ~clk;

    sequence_memory_reader #(.ADDR_W(AW), .READ_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .iClock(clk), .iReset(iReset), .iStart(iStart),
        .iSequencesToProcess(iSequencesToProcess), .iBaseAddress(iBaseAddress),
        .oMemAddress(oMemAddress), .oMemChipSelect(oMemChipSelect), .oMemClken(oMemClken),
        .iMemReadData(iMemReadData), .oSeqValid(oSeqValid), .iSeqReady(iSeqReady),
        .oSeqInput(oSeqInput), .oSeqExpected(oSeqExpected), .oSeqValidMask(oSeqValidMask),
        .oSeqIndex(oSeqIndex), .oSeqLast(oSeqLast), .oBusy(oBusy), .oDone(oDone),
`ifdef SEQ_READER_CHECKSUM_EN
        .oChecksum(oChecksum),
`endif
        .iDoneAck(iDoneAck)
    );

    assign cur = {oSeqIndex, oSeqLast, oSeqInput, oSeqExpected, oSeqValidMask};

    // Single-cycle-latency RAM, fed from request values sampled mid-cycle.
    always @(posedge clk) if (cs_n) iMemReadData <= mem[addr_n];

    initial begin
        iSeqReady = 1'b1;
        forever begin
            @(posedge clk); #1;
            iSeqReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: records reads issued and entries accepted at the coming edge.
    always @(negedge clk) begin
        cyc++;
        cs_n   = oMemChipSelect;
        addr_n = oMemAddress;
        if (iReset) begin
            issued = 0;
            acc    = 0;
            hold_f = 0;
        end else begin
            if (oMemChipSelect) begin
                addr_q.push_back(oMemAddress);
                issued++;
                if (first_cs < 0) first_cs = cyc;
            end
            if (oSeqValid && first_v < 0) first_v = cyc;
            if (oSeqValid && iSeqReady) begin
                ent_q.push_back(cur);
                acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (hold_f && (!oSeqValid || cur !== held)) stab_viol++;
            hold_f = oSeqValid && !iSeqReady;
            held   = cur;
            if (issued - acc > D) out_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        ent_q.delete();
        addr_q.delete();
        first_cs = -1; first_v = -1; first_acc = -1; last_acc = -1;
    endtask

    task automatic launch(input int n, input logic [AW-1:0] base, input bit fill, input bit rnd);
        if (fill) for (int i = 0; i < n; i++) mem[AW'(base + i)] = $urandom;
        clear_log();
        rnd_rdy             = rnd;
        iSequencesToProcess = 8'(n);
        iBaseAddress        = base;
        iStart              = 1'b1;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (oDone) break;
        end
        chk("done_timeout", 64'(k < 3000), 64'd1);
    endtask

    // Reference: entry i is word base+i (wrapping), split into bytes, tagged with i and last.
    task automatic check_run(input int n, input logic [AW-1:0] base);
        logic [31:0] w, sum;
        logic [AW-1:0] a;
        sum = 0;
        chk("n_entries", 64'(ent_q.size()), 64'(n));
        chk("n_reads", 64'(addr_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = AW'(base + i);
            w = mem[a];
            sum = sum + w;
            if (i < ent_q.size())
                chk($sformatf("entry%0d", i), 64'(ent_q[i]), 64'({8'(i), i == n - 1, w[7:0], w[15:8], w[23:16]}));
            if (i < addr_q.size())
                chk($sformatf("addr%0d", i), 64'(addr_q[i]), 64'(a));
        end
        chk("stable_hold", 64'(stab_viol), 64'd0);
        chk("outstanding", 64'(out_viol), 64'd0);
`ifdef SEQ_READER_CHECKSUM_EN
        chk("checksum", 64'(oChecksum), 64'(sum));
`endif
    endtask

    task automatic ack();
        @(posedge clk); #1;
        iStart   = 1'b0;
        iDoneAck = 1'b1;
        @(posedge clk); #1;
        iDoneAck = 1'b0;
        @(negedge clk);
        chk("done_drop", 64'(oDone), 64'd0);
        chk("idle_busy", 64'(oBusy), 64'd0);
    endtask

    task automatic run(input int n, input logic [AW-1:0] base, input bit rnd);
        step(1);
        launch(n, base, 1, rnd);
        wait_done();
        check_run(n, base);
        ack();
    endtask

    initial begin
        logic [AW-1:0] b;
        iReset = 1'b1; iStart = 1'b0; iDoneAck = 1'b0;
        iSequencesToProcess = '0; iBaseAddress = '0;
        clear_log();
        step(3);
        @(negedge clk);
        chk("reset_outs", 64'({oMemChipSelect, oSeqValid, oBusy, oDone, cur, oMemAddress}), 64'd0);
        chk("reset_clken", 64'(oMemClken), 64'd1);
        step(1);
        iReset = 1'b0;

        // Case 1: fixed table, ready held high
        step(1);
        for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'h00FF0A01 + i;
        launch(4, 16'h0010, 0, 0);
        wait_done();
        check_run(4, 16'h0010);
        chk("first_entry", 64'(ent_q.size() > 0 ? ent_q[0] : '0), 64'({8'd0, 1'b0, 8'h01, 8'h0A, 8'hFF}));
        chk("latency", 64'(first_v - first_cs), 64'(L + 1));
        chk("throughput", 64'(last_acc - first_acc), 64'd3);
        repeat (3) @(negedge clk);
        chk("done_hold", 64'({oDone, oBusy}), 64'b10);
        ack();

        // Case 2: N=0
        step(1);
        launch(0, 16'h1234, 0, 0);
        @(posedge clk); @(negedge clk);
        chk("n0_done", 64'(oDone), 64'd1);
        chk("n0_reads", 64'(addr_q.size()), 64'd0);
        chk("n0_entries", 64'(ent_q.size()), 64'd0);
        ack();

        // Case 3: random backpressure
        run(8, 16'($urandom), 1);
        run(40, 16'($urandom), 1);

        // Case 4: address wrap
        run(4, 16'hFFFE, 1);

        // Case 5: reset mid-fetch with start held high
        step(1);
        b = 16'($urandom);
        launch(30, b, 1, 1);
        step(6);
        iReset = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 64'({oMemChipSelect, oSeqValid, oBusy, oDone, cur}), 64'd0);
        chk("midrst_clken", 64'(oMemClken), 64'd1);
        step(2);
        iReset  = 1'b0;
        rnd_rdy = 0;
        clear_log();
        step(5);
        @(negedge clk);
        chk("no_restart", 64'({oBusy, oDone, oSeqValid}), 64'd0);
        chk("no_stale", 64'(ent_q.size() + addr_q.size()), 64'd0);
        step(1);
        iStart = 1'b0;
        run(2, 16'($urandom), 0);

`ifdef SEQ_READER_CHECKSUM_EN
        // Case 6: checksum wraps
        step(1);
        mem[16'h0200] = 32'h80000000;
        mem[16'h0201] = 32'h80000000;
        launch(2, 16'h0200, 0, 0);
        wait_done();
        chk("checksum_wrap", 64'(oChecksum), 64'd0);
        ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
